ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Parametrised PS/2 scan-code decoder sitting between `ps2_keyboard` (byte receiver) and the ASCII/display logic. It pops bytes from the receiver, parses Set-2 prefixes (E0 extended, F0 break), tracks Shift/Ctrl/Alt/CapsLock state, and suppresses typematic repeats. Resulting key events go into a show-ahead FIFO with a valid/ready handshake. It replaces the single-register break/CapsLock handling with a lossless, counted event stream.

## Interface
- `FIFO_DEPTH`, 8, event FIFO depth; power of two, ≥2.
- `SUPPRESS_REPEAT`, 1, 1 = drop typematic repeat makes; 0 = pass them as events.
- `clk` in 1: system clock.
- `clrn` in 1: reset, synchronous, active-low.
- `kb_data` in 8: byte from `ps2_keyboard`.
- `kb_ready` in 1: receiver has a byte.
- `kb_overflow` in 1: receiver overflow flag.
- `kb_nextdata_n` out 1: active-low one-cycle pop strobe to receiver.
- `ev_valid` out 1: FIFO head valid.
- `ev_ready` in 1: consumer accepts head.
- `ev_code` out 8: scan code of head event.
- `ev_ext` out 1: head event was E0-prefixed.
- `ev_break` out 1: head event is a release.
- `ev_mods` out 4: {caps, alt, ctrl, shift} snapshot stored with head event.
- `caps_lock` out 1: live CapsLock state.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: entries held.
- `press_count` out 8: non-suppressed make events, wraps 255→0.
- `drop_count` out 8: events lost to full FIFO, saturates at 255.
- `ovf_seen` out 1: sticky, set by `kb_overflow`.

## Operation
- Reset (`clrn`=0 at posedge): `kb_nextdata_n`=1, FIFO empty, `ev_valid`=0, `ev_code`/`ev_ext`/`ev_break`/`ev_mods`=0, all modifiers and `caps_lock`=0, counters 0, `ovf_seen`=0, parser in P_IDLE, last-make register invalid. A reset mid-sequence discards pending prefixes and any strobe in flight.
- Pop handshake: byte consumed in cycle t when `kb_ready`=1 and lockout clear; `kb_nextdata_n`=0 during t+1 only; no byte is consumed in t+1 or t+2 (lockout while receiver updates `ready`).
- Parser states: P_IDLE, P_E0, P_F0, P_E0F0.
  - E0: P_IDLE→P_E0, P_F0→P_E0F0 (E0 after F0 is accepted).
  - F0: P_IDLE→P_F0, P_E0→P_E0F0.
  - E1, AA, FA, EE, FE, 00, FF: discarded, parser→P_IDLE, no event.
  - Any other byte: forms event {code, ext = state∈{P_E0,P_E0F0}, break = state∈{P_F0,P_E0F0}}, parser→P_IDLE.
- Modifiers: shift = L(12) OR R(59), tracked as two bits; ctrl = 14 (ext or not); alt = 11 (ext or not). Make sets, break clears.
- CapsLock: non-ext make of 58 toggles `caps_lock`, only when not suppressed as a repeat.
- Repeat suppression: last-make register holds {ext, code} of the most recent make. A make equal to it is a repeat. With SUPPRESS_REPEAT=1 it produces no event, no count, and no caps toggle. A break of that key invalidates the register.
- `ev_mods` equals modifier state after applying the event itself: the Shift make carries shift=1; the Shift break carries shift=0.
- FIFO push succeeds if level<FIFO_DEPTH or a pop occurs in the same cycle. Otherwise the event is dropped and `drop_count` increments with saturation. Modifier, caps and `press_count` updates still happen.
- `press_count` increments on every non-suppressed make, including dropped ones.
- `kb_overflow`=1 in any cycle: `ovf_seen`←1, parser→P_IDLE, last-make invalidated. A byte consumed in the same cycle is discarded.

## Timing
- Byte consumed in cycle t gives a FIFO write at end of t. With the FIFO empty, `ev_valid`=1 and head fields valid from t+1.
- Pop: `ev_valid` and `ev_ready` both 1 at a posedge. The next head, or `ev_valid`=0, appears the following cycle.
- `fifo_level`, counters, `caps_lock` and modifiers update at end of the consuming cycle.
- Maximum byte throughput: one byte per 3 cycles.

## Test plan
- Reset, then bytes 1C, F0 1C with `ev_ready`=1 → events {1C,ext0,brk0}, {1C,ext0,brk1}; `kb_nextdata_n` exactly one low cycle per byte; `press_count`=1.
- E0 75, E0 F0 75 → {75,ext1,brk0}, {75,ext1,brk1}; parser back in P_IDLE, verified by a following 1C decoding with ext0.
- 12, 1C, F0 1C, F0 12 → `ev_mods` shift bit 1,1,1,0.
- 58 58 58 F0 58 with SUPPRESS_REPEAT=1 → `caps_lock`=1, two events only; rerun with SUPPRESS_REPEAT=0 → three makes, `caps_lock`=1 (odd toggles).
- `ev_ready`=0, FIFO_DEPTH=8, feed 10 distinct makes → `fifo_level`=8, `drop_count`=2, `press_count`=10. Then a push while popping at full → accepted, `drop_count` stays 2.
- E0, then `kb_overflow` pulse, then 75 → {75,ext0}, `ovf_seen`=1. `clrn`=0 after F0 → next 1C decoded as make.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: pops bytes from the receiver, parses E0/F0 prefixes,
// tracks modifiers and CapsLock, suppresses typematic repeats, and queues key events.
module ps2_key_decoder #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter bit          SUPPRESS_REPEAT = 1'b1
) (
  input  logic                            i_clk,
  input  logic                            i_clrn,
  input  logic [7:0]                      i_kb_data,
  input  logic                            i_kb_ready,
  input  logic                            i_kb_overflow,
  output logic                            o_kb_nextdata_n,
  output logic                            o_ev_valid,
  input  logic                            i_ev_ready,
  output logic [7:0]                      o_ev_code,
  output logic                            o_ev_ext,
  output logic                            o_ev_break,
  output logic [3:0]                      o_ev_mods,
  output logic                            o_caps_lock,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
  output logic [7:0]                      o_press_count,
  output logic [7:0]                      o_drop_count,
  output logic                            o_ovf_seen
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {P_IDLE, P_E0, P_F0, P_E0F0} parse_e;

  parse_e       r_state, w_state_next;
  logic         r_pop;
  logic [1:0]   r_lock;
  logic         r_lshift, r_rshift, r_ctrl, r_alt, r_caps;
  logic         w_lshift, w_rshift, w_ctrl, w_alt, w_caps;
  logic [8:0]   r_last;
  logic         r_last_valid;
  logic [13:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic [7:0]   r_press, r_drop;
  logic         r_ovf;

  logic w_take, w_byte_ok, w_is_e0, w_is_f0, w_is_junk, w_ev, w_ext, w_brk;
  logic w_repeat, w_suppress, w_push, w_pop, w_can_push;

  // Lockout keeps the receiver's stale ready from being consumed twice.
  assign w_take    = i_kb_ready && (r_lock == 2'd0);
  assign w_byte_ok = w_take && !i_kb_overflow;
  assign w_is_e0   = (i_kb_data == 8'hE0);
  assign w_is_f0   = (i_kb_data == 8'hF0);

  always_comb begin
    w_is_junk = 1'b0;
    case (i_kb_data)
      8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: w_is_junk = 1'b1;
      default:                                         w_is_junk = 1'b0;
    endcase
  end

  assign w_ext      = (r_state == P_E0) || (r_state == P_E0F0);
  assign w_brk      = (r_state == P_F0) || (r_state == P_E0F0);
  assign w_ev       = w_byte_ok && !w_is_e0 && !w_is_f0 && !w_is_junk;
  assign w_repeat   = !w_brk && r_last_valid && (r_last == {w_ext, i_kb_data});
  assign w_suppress = SUPPRESS_REPEAT && w_repeat;
  assign w_push     = w_ev && !w_suppress;
  assign w_pop      = (r_level != '0) && i_ev_ready;
  assign w_can_push = (r_level < DEPTH_L) || w_pop;

  always_comb begin
    w_state_next = r_state;
    if (i_kb_overflow) begin
      w_state_next = P_IDLE;
    end else if (w_take) begin
      if (w_is_e0) begin
        if (r_state == P_IDLE)     w_state_next = P_E0;
        else if (r_state == P_F0)  w_state_next = P_E0F0;
      end else if (w_is_f0) begin
        if (r_state == P_IDLE)     w_state_next = P_F0;
        else if (r_state == P_E0)  w_state_next = P_E0F0;
      end else begin
        w_state_next = P_IDLE;
      end
    end
  end

  // Modifier state after applying the current event; also stored with the event.
  always_comb begin
    w_lshift = r_lshift;
    w_rshift = r_rshift;
    w_ctrl   = r_ctrl;
    w_alt    = r_alt;
    w_caps   = r_caps;
    if (w_ev) begin
      if (!w_ext && i_kb_data == 8'h12) w_lshift = !w_brk;
      if (!w_ext && i_kb_data == 8'h59) w_rshift = !w_brk;
      if (i_kb_data == 8'h14)           w_ctrl   = !w_brk;
      if (i_kb_data == 8'h11)           w_alt    = !w_brk;
      if (!w_ext && !w_brk && !w_suppress && i_kb_data == 8'h58) w_caps = !r_caps;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clrn) begin
      r_state      <= P_IDLE;
      r_pop        <= 1'b0;
      r_lock       <= 2'd0;
      r_lshift     <= 1'b0;
      r_rshift     <= 1'b0;
      r_ctrl       <= 1'b0;
      r_alt        <= 1'b0;
      r_caps       <= 1'b0;
      r_last       <= '0;
      r_last_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pop    <= w_take;
      r_lock   <= w_take ? 2'd2 : (r_lock != 2'd0 ? r_lock - 2'd1 : 2'd0);
      r_lshift <= w_lshift;
      r_rshift <= w_rshift;
      r_ctrl   <= w_ctrl;
      r_alt    <= w_alt;
      r_caps   <= w_caps;
      if (i_kb_overflow) begin
        r_ovf        <= 1'b1;
        r_last_valid <= 1'b0;
      end else if (w_ev) begin
        if (!w_brk) begin
          r_last       <= {w_ext, i_kb_data};
          r_last_valid <= 1'b1;
        end else if (r_last == {w_ext, i_kb_data}) begin
          r_last_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && w_can_push) begin
      r_mem[r_wptr] <= {i_kb_data, w_ext, w_brk, w_caps, w_alt, w_ctrl, w_lshift | w_rshift};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clrn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_press <= 8'd0;
      r_drop  <= 8'd0;
    end else begin
      if (w_push && w_can_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)                r_rptr <= r_rptr + 1'b1;
      if (w_push && w_can_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!(w_push && w_can_push) && w_pop) r_level <= r_level - 1'b1;
      if (w_push && !w_brk)                    r_press <= r_press + 8'd1;
      if (w_push && !w_can_push && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  always_comb begin
    o_ev_code  = 8'h00;
    o_ev_ext   = 1'b0;
    o_ev_break = 1'b0;
    o_ev_mods  = 4'h0;
    if (r_level != '0) begin
      {o_ev_code, o_ev_ext, o_ev_break, o_ev_mods} = r_mem[r_rptr];
    end
  end

  assign o_kb_nextdata_n = !r_pop;
  assign o_ev_valid      = (r_level != '0);
  assign o_caps_lock     = r_caps;
  assign o_fifo_level    = r_level;
  assign o_press_count   = r_press;
  assign o_drop_count    = r_drop;
  assign o_ovf_seen      = r_ovf;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; a second instance runs with repeat suppression off.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       ev_ready = 1'b0;

  logic       a_nextdata_n, a_ev_valid, a_ev_ext, a_ev_break, a_caps, a_ovf;
  logic [7:0] a_ev_code, a_press, a_drop;
  logic [3:0] a_ev_mods, a_level;
  logic       b_nextdata_n, b_ev_valid, b_ev_ext, b_ev_break, b_caps, b_ovf;
  logic [7:0] b_ev_code, b_press, b_drop;
  logic [3:0] b_ev_mods, b_level;

  ps2_key_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1'b1)) dut (
    .i_clk(clk), .i_clrn(clrn), .i_kb_data(kb_data), .i_kb_ready(kb_ready),
    .i_kb_overflow(kb_overflow), .o_kb_nextdata_n(a_nextdata_n), .o_ev_valid(a_ev_valid),
    .i_ev_ready(ev_ready), .o_ev_code(a_ev_code), .o_ev_ext(a_ev_ext),
    .o_ev_break(a_ev_break), .o_ev_mods(a_ev_mods), .o_caps_lock(a_caps),
    .o_fifo_level(a_level), .o_press_count(a_press), .o_drop_count(a_drop),
    .o_ovf_seen(a_ovf)
  );

  ps2_key_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1'b0)) dut_nr (
    .i_clk(clk), .i_clrn(clrn), .i_kb_data(kb_data), .i_kb_ready(kb_ready),
    .i_kb_overflow(kb_overflow), .o_kb_nextdata_n(b_nextdata_n), .o_ev_valid(b_ev_valid),
    .i_ev_ready(ev_ready), .o_ev_code(b_ev_code), .o_ev_ext(b_ev_ext),
    .o_ev_break(b_ev_break), .o_ev_mods(b_ev_mods), .o_caps_lock(b_caps),
    .o_fifo_level(b_level), .o_press_count(b_press), .o_drop_count(b_drop),
    .o_ovf_seen(b_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int strobes  = 0;
  logic [13:0] q0[$];
  logic [13:0] q1[$];

  // Popped events and strobe cycles, sampled at the edge that consumes them.
  always @(posedge clk) begin
    if (a_nextdata_n === 1'b0) strobes = strobes + 1;
    if (a_ev_valid && ev_ready) q0.push_back({a_ev_code, a_ev_ext, a_ev_break, a_ev_mods});
    if (b_ev_valid && ev_ready) q1.push_back({b_ev_code, b_ev_ext, b_ev_break, b_ev_mods});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ev(input logic [7:0] c, input logic e, input logic b,
                                     input logic [3:0] m);
    return {c, e, b, m};
  endfunction

  task automatic check_ev(input string tag, input int idx, input logic [13:0] exp);
    logic [13:0] got;
    got = (q0.size() > idx) ? q0[idx] : 14'h3FFF;
    check_eq(tag, {18'd0, got}, {18'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    idle(2);
    clrn = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    kb_data  = b;
    kb_ready = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (a_nextdata_n == 1'b0) seen = 1'b1;
    end
    kb_ready = 1'b0;
    check_eq("strobe_seen", {31'd0, seen}, 32'd1);
  endtask

  logic [7:0] codes [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
                             8'h44, 8'h4D};

  initial begin
    do_reset();
    idle(1);
    check_eq("rst_valid", {31'd0, a_ev_valid}, 32'd0);
    check_eq("rst_nextdata_n", {31'd0, a_nextdata_n}, 32'd1);
    check_eq("rst_level", {28'd0, a_level}, 32'd0);
    check_eq("rst_head", {18'd0, a_ev_code, a_ev_ext, a_ev_break, a_ev_mods}, 32'd0);
    check_eq("rst_counts", {16'd0, a_press, a_drop}, 32'd0);
    check_eq("rst_flags", {30'd0, a_caps, a_ovf}, 32'd0);

    // Basic make/break
    ev_ready = 1'b1;
    strobes  = 0;
    q0.delete();
    q1.delete();
    send(8'h1C); send(8'hF0); send(8'h1C);
    idle(4);
    check_eq("t1_nev", q0.size(), 32'd2);
    check_ev("t1_make", 0, ev(8'h1C, 1'b0, 1'b0, 4'h0));
    check_ev("t1_break", 1, ev(8'h1C, 1'b0, 1'b1, 4'h0));
    check_eq("t1_strobes", strobes, 32'd3);
    check_eq("t1_press", {24'd0, a_press}, 32'd1);

    // Extended make/break, then parser back to idle
    q0.delete();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h1C);
    idle(4);
    check_eq("t2_nev", q0.size(), 32'd3);
    check_ev("t2_make", 0, ev(8'h75, 1'b1, 1'b0, 4'h0));
    check_ev("t2_break", 1, ev(8'h75, 1'b1, 1'b1, 4'h0));
    check_ev("t2_idle", 2, ev(8'h1C, 1'b0, 1'b0, 4'h0));

    // Shift snapshot
    q0.delete();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    idle(4);
    check_eq("t3_nev", q0.size(), 32'd4);
    check_ev("t3_shift_make", 0, ev(8'h12, 1'b0, 1'b0, 4'h1));
    check_ev("t3_key_make", 1, ev(8'h1C, 1'b0, 1'b0, 4'h1));
    check_ev("t3_key_break", 2, ev(8'h1C, 1'b0, 1'b1, 4'h1));
    check_ev("t3_shift_break", 3, ev(8'h12, 1'b0, 1'b1, 4'h0));
    check_eq("t3_press", {24'd0, a_press}, 32'd5);

    // CapsLock with repeats
    q0.delete();
    q1.delete();
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    idle(4);
    check_eq("t4_caps", {31'd0, a_caps}, 32'd1);
    check_eq("t4_nev", q0.size(), 32'd2);
    check_ev("t4_make", 0, ev(8'h58, 1'b0, 1'b0, 4'h8));
    check_ev("t4_break", 1, ev(8'h58, 1'b0, 1'b1, 4'h8));
    check_eq("t4_press", {24'd0, a_press}, 32'd6);
    check_eq("t4nr_caps", {31'd0, b_caps}, 32'd1);
    check_eq("t4nr_nev", q1.size(), 32'd4);
    check_eq("t4nr_mid_mods", (q1.size() > 1) ? {18'd0, q1[1]} : 32'hFFFF,
             {18'd0, ev(8'h58, 1'b0, 1'b0, 4'h0)});
    check_eq("t4nr_press", {24'd0, b_press}, 32'd8);

    // FIFO full and drop accounting
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(codes[i]);
    idle(3);
    check_eq("t5_level", {28'd0, a_level}, 32'd8);
    check_eq("t5_drop", {24'd0, a_drop}, 32'd2);
    check_eq("t5_press", {24'd0, a_press}, 32'd10);
    check_eq("t5_valid", {31'd0, a_ev_valid}, 32'd1);
    q0.delete();
    @(negedge clk);
    kb_data  = 8'h1B;
    kb_ready = 1'b1;
    ev_ready = 1'b1;
    @(negedge clk);
    kb_ready = 1'b0;
    ev_ready = 1'b0;
    check_eq("t5_push_pop_level", {28'd0, a_level}, 32'd8);
    check_eq("t5_push_pop_drop", {24'd0, a_drop}, 32'd2);
    check_eq("t5_push_pop_press", {24'd0, a_press}, 32'd11);
    check_ev("t5_popped", 0, ev(8'h15, 1'b0, 1'b0, 4'h0));
    q0.delete();
    ev_ready = 1'b1;
    idle(12);
    check_eq("t5_drain_n", q0.size(), 32'd8);
    check_ev("t5_drain_first", 0, ev(8'h1D, 1'b0, 1'b0, 4'h0));
    check_ev("t5_drain_last", 7, ev(8'h1B, 1'b0, 1'b0, 4'h0));
    check_eq("t5_empty", {31'd0, a_ev_valid}, 32'd0);

    // Overflow clears pending prefix
    q0.delete();
    send(8'hE0);
    idle(3);
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    send(8'h75);
    idle(4);
    check_eq("t6_nev", q0.size(), 32'd1);
    check_ev("t6_no_ext", 0, ev(8'h75, 1'b0, 1'b0, 4'h0));
    check_eq("t6_ovf", {31'd0, a_ovf}, 32'd1);

    // Reset discards a pending break prefix
    send(8'hF0);
    do_reset();
    check_eq("t7_ovf_cleared", {31'd0, a_ovf}, 32'd0);
    q0.delete();
    send(8'h1C);
    idle(4);
    check_eq("t7_nev", q0.size(), 32'd1);
    check_ev("t7_make", 0, ev(8'h1C, 1'b0, 1'b0, 4'h0));
    check_eq("t7_press", {24'd0, a_press}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
